tcdm_initiator_adapter: RTL and testbench

Core-side initiator for the TCDM valid/ready request protocol: accepts single-cycle req/gnt transactions from a core and issues them onto the interconnect. Each request is tagged with a metadata word identifying the core and a transaction ID. Out-of-order responses are collected in a reorder buffer (ROB) and returned to the core in issue order. It is the opposite end of the bank-side adapter: it produces the metadata that the bank side stores and echoes back, including for LR, SC and AMO requests.

---
 rtl/tcdm_initiator_adapter_if.sv | 53 +++++
 rtl/tcdm_initiator_adapter.sv | 165 ++++++++++++++++
 tb/tb_tcdm_initiator_adapter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_initiator_adapter_if.sv
// Core-side and interconnect-side signal bundle for the TCDM initiator adapter.
// Signal names keep the adapter's point of view: _i is driven into the adapter, _o out of it.
interface tcdm_initiator_adapter_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MetaWidth = 10
);
    // Core request / response
    logic                   core_req_i;
    logic                   core_gnt_o;
    logic [AddrWidth-1:0]   core_addr_i;
    logic [3:0]             core_amo_i;
    logic                   core_write_i;
    logic [DataWidth-1:0]   core_wdata_i;
    logic [DataWidth/8-1:0] core_be_i;
    logic                   core_rvalid_o;
    logic                   core_rready_i;
    logic [DataWidth-1:0]   core_rdata_o;

    // Interconnect request
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [AddrWidth-1:0]   out_address_o;
    logic [3:0]             out_amo_o;
    logic                   out_write_o;
    logic [DataWidth-1:0]   out_wdata_o;
    logic [DataWidth/8-1:0] out_be_o;
    logic [MetaWidth-1:0]   out_meta_o;

    // Interconnect response
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [DataWidth-1:0]   in_rdata_i;
    logic [MetaWidth-1:0]   in_meta_i;

    // Adapter side
    modport slave (
        input  core_req_i, core_addr_i, core_amo_i, core_write_i, core_wdata_i, core_be_i,
        input  core_rready_i, out_ready_i, in_valid_i, in_rdata_i, in_meta_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output out_valid_o, out_address_o, out_amo_o, out_write_o, out_wdata_o, out_be_o,
        output out_meta_o, in_ready_o
    );

    // Core plus interconnect side (drives the adapter)
    modport master (
        output core_req_i, core_addr_i, core_amo_i, core_write_i, core_wdata_i, core_be_i,
        output core_rready_i, out_ready_i, in_valid_i, in_rdata_i, in_meta_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  out_valid_o, out_address_o, out_amo_o, out_write_o, out_wdata_o, out_be_o,
        input  out_meta_o, in_ready_o
    );
endinterface

// File: rtl/tcdm_initiator_adapter.sv
// TCDM initiator adapter: tags core requests with {ini_addr, tile_id, core_id, id} metadata,
// collects out-of-order responses in a reorder buffer and returns them in issue order.
module tcdm_initiator_adapter #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned IniAddrWidth   = 2,
    parameter int unsigned TileIdWidth    = 4,
    parameter int unsigned CoreIdWidth    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [IniAddrWidth-1:0] ini_addr_i,
    input  logic [TileIdWidth-1:0]  tile_id_i,
    input  logic [CoreIdWidth-1:0]  core_id_i,
    tcdm_initiator_adapter_if.slave bus_io,
    output logic                    err_o
);
    localparam int unsigned IdWidth    = $clog2(NumOutstanding);
    localparam int unsigned IdentWidth = IniAddrWidth + TileIdWidth + CoreIdWidth;
    localparam int unsigned MetaWidth  = IdentWidth + IdWidth;

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLr   = 4'hA;

    typedef logic [IdWidth-1:0] id_t;
    typedef logic [IdWidth:0]   cnt_t;

    localparam cnt_t CountFull = cnt_t'(NumOutstanding);

    if (DataWidth != 32) begin : gen_bad_data_width
        $error("tcdm_initiator_adapter: only DataWidth = 32 is supported");
    end
    if ((NumOutstanding < 2) || ((NumOutstanding & (NumOutstanding - 1)) != 0))
    begin : gen_bad_depth
        $error("tcdm_initiator_adapter: NumOutstanding must be a power of two >= 2");
    end

    // ROB state
    id_t                  head_q, head_d;
    id_t                  tail_q, tail_d;
    cnt_t                 count_q, count_d;
    logic [NumOutstanding-1:0] valid_q, valid_d;
    logic [DataWidth-1:0] data_q [NumOutstanding];
    logic                 lr_pending_q, lr_pending_d;
    id_t                  lr_id_q, lr_id_d;
    logic                 err_q, err_d;

    logic [IdentWidth-1:0] ident;
    logic [IdentWidth-1:0] rsp_ident;
    id_t                   rsp_id;
    id_t                   rsp_rel;
    logic [AddrWidth-1:0]  req_addr;
    logic                  expects_rsp;
    logic                  is_lr;
    logic                  stall;
    logic                  req_valid;
    logic                  req_gnt;
    logic                  alloc;
    logic                  pop;
    logic                  rsp_ok;
    logic                  rsp_write;

    assign ident = {ini_addr_i, tile_id_i, core_id_i};

    // Request side: everything but plain stores expects a response and needs a ROB slot.
    assign expects_rsp = !(bus_io.core_write_i && (bus_io.core_amo_i == AmoNone));
    assign is_lr       = (bus_io.core_amo_i == AmoLr);
    // Registered count only: a pop in the same cycle does not free the slot yet.
    assign stall       = expects_rsp && ((count_q == CountFull) || (is_lr && lr_pending_q));
    assign req_valid   = bus_io.core_req_i && !stall;
    assign req_gnt     = req_valid && bus_io.out_ready_i;
    assign alloc       = req_gnt && expects_rsp;

    assign req_addr             = bus_io.core_addr_i;
    assign bus_io.out_valid_o   = req_valid;
    assign bus_io.core_gnt_o    = req_gnt;
    assign bus_io.out_address_o = req_addr;
    assign bus_io.out_amo_o     = bus_io.core_amo_i;
    // Atomics go out as reads; the bank side performs the write itself.
    assign bus_io.out_write_o   = bus_io.core_write_i && (bus_io.core_amo_i == AmoNone);
    assign bus_io.out_wdata_o   = bus_io.core_wdata_i;
    assign bus_io.out_be_o      = bus_io.core_be_i;
    assign bus_io.out_meta_o    = {ident, tail_q};

    // Response side: accept only our own identity, an allocated slot, not yet filled.
    assign rsp_ident = bus_io.in_meta_i[MetaWidth-1:IdWidth];
    assign rsp_id    = bus_io.in_meta_i[IdWidth-1:0];
    // Slot is allocated when its distance from head (mod N) is below the occupancy.
    assign rsp_rel   = rsp_id - head_q;
    assign rsp_ok    = (rsp_ident == ident) && !valid_q[rsp_id] && ({1'b0, rsp_rel} < count_q);
    assign rsp_write = bus_io.in_valid_i && rsp_ok;

    assign bus_io.in_ready_o    = 1'b1;
    assign bus_io.core_rvalid_o = valid_q[head_q];
    assign bus_io.core_rdata_o  = data_q[head_q];
    assign pop                  = valid_q[head_q] && bus_io.core_rready_i;

    assign err_o = err_q;

    // Next-state for pointers, occupancy, valid bits, LR reservation and the error flag.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + cnt_t'(alloc) - cnt_t'(pop);
        valid_d      = valid_q;
        lr_pending_d = lr_pending_q;
        lr_id_d      = lr_id_q;
        err_d        = err_q;

        if (alloc) begin
            tail_d = tail_q + 1'b1;
        end
        // pop needs valid set and a write needs valid clear, so they never hit the same slot
        if (pop) begin
            head_d          = head_q + 1'b1;
            valid_d[head_q] = 1'b0;
        end
        if (rsp_write) begin
            valid_d[rsp_id] = 1'b1;
        end
        // Set and clear are exclusive: a new LR is only granted when none is pending.
        if (alloc && is_lr) begin
            lr_pending_d = 1'b1;
            lr_id_d      = tail_q;
        end else if (rsp_write && lr_pending_q && (rsp_id == lr_id_q)) begin
            lr_pending_d = 1'b0;
        end
        if (bus_io.in_valid_i && !rsp_ok) begin
            err_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            lr_pending_q <= 1'b0;
            lr_id_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            lr_pending_q <= lr_pending_d;
            lr_id_q      <= lr_id_d;
            err_q        <= err_d;
        end
    end

    // ROB data storage; cleared on reset so core_rdata_o reads 0 afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumOutstanding; i++) begin
                data_q[i] <= '0;
            end
        end else if (rsp_write) begin
            data_q[rsp_id] <= bus_io.in_rdata_i;
        end
    end
endmodule

// File: tb/tb_tcdm_initiator_adapter.sv
// Directed bench for tcdm_initiator_adapter with a queue-based reference model checked every cycle.
module tb_tcdm_initiator_adapter;
    localparam int unsigned N = 4;
    localparam logic [1:0] Ini  = 2'b01;
    localparam logic [3:0] Tile = 4'h5;
    localparam logic [1:0] Core = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    always #5 clk = ~clk;

    tcdm_initiator_adapter_if #(.AddrWidth(32), .DataWidth(32), .MetaWidth(10)) bus ();

    tcdm_initiator_adapter #(
        .AddrWidth(32), .DataWidth(32), .NumOutstanding(N),
        .IniAddrWidth(2), .TileIdWidth(4), .CoreIdWidth(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .ini_addr_i(Ini), .tile_id_i(Tile), .core_id_i(Core),
        .bus_io(bus), .err_o(err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: in-order list of outstanding responses.
    typedef struct {
        logic [1:0]  id;
        bit          is_lr;
        bit          have;
        logic [31:0] data;
    } ent_t;

    ent_t pend[$];
    int n_alloc = 0;
    bit m_err = 1'b0;
    bit chk_en = 1'b0;
    logic [31:0] got[$];

    task automatic model_cycle();
        bit expects, lr_busy, stall, e_ov, e_gnt, e_rv, found;
        int idx;
        logic [1:0] rid;
        ent_t e;
        expects = !(bus.core_write_i && bus.core_amo_i == 4'h0);
        lr_busy = 1'b0;
        foreach (pend[i]) if (pend[i].is_lr && !pend[i].have) lr_busy = 1'b1;
        stall = expects && (pend.size() == N || (bus.core_amo_i == 4'hA && lr_busy));
        e_ov  = bus.core_req_i && !stall;
        e_gnt = e_ov && bus.out_ready_i;
        e_rv  = (pend.size() > 0) && pend[0].have;
        chk("out_valid", bus.out_valid_o, e_ov);
        chk("core_gnt", bus.core_gnt_o, e_gnt);
        chk("core_rvalid", bus.core_rvalid_o, e_rv);
        if (e_rv) chk("core_rdata", bus.core_rdata_o, pend[0].data);
        chk("err", err, m_err);
        chk("in_ready", bus.in_ready_o, 1);
        if (e_ov) begin
            chk("out_write", bus.out_write_o, bus.core_write_i && bus.core_amo_i == 4'h0);
            chk("out_addr", bus.out_address_o, bus.core_addr_i);
            if (expects) chk("out_meta", bus.out_meta_o, {Ini, Tile, Core, 2'(n_alloc % N)});
        end
        if (!rst_n) begin
            pend.delete();
            n_alloc = 0;
            m_err = 1'b0;
            return;
        end
        if (bus.in_valid_i) begin
            rid = bus.in_meta_i[1:0];
            found = 1'b0;
            idx = 0;
            foreach (pend[i]) if (pend[i].id == rid) begin
                found = 1'b1;
                idx = i;
            end
            if (found && bus.in_meta_i[9:2] == {Ini, Tile, Core} && !pend[idx].have) begin
                e = pend[idx];
                e.have = 1'b1;
                e.data = bus.in_rdata_i;
                pend[idx] = e;
            end else begin
                m_err = 1'b1;
            end
        end
        if (e_rv && bus.core_rready_i) pend.delete(0);
        if (e_gnt && expects) begin
            e.id = 2'(n_alloc % N);
            e.is_lr = (bus.core_amo_i == 4'hA);
            e.have = 1'b0;
            e.data = '0;
            pend.push_back(e);
            n_alloc++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.core_rvalid_o === 1'b1 && bus.core_rready_i) got.push_back(bus.core_rdata_o);
        if (chk_en) model_cycle();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.core_req_i = 0; bus.core_addr_i = '0; bus.core_amo_i = '0; bus.core_write_i = 0;
        bus.core_wdata_i = '0; bus.core_be_i = 4'hF; bus.core_rready_i = 1; bus.out_ready_i = 1;
        bus.in_valid_i = 0; bus.in_rdata_i = '0; bus.in_meta_i = '0;
    endtask

    task automatic set_req(input logic wr, input logic [3:0] amo, input logic [31:0] addr,
                           input logic [31:0] wd);
        bus.core_req_i = 1; bus.core_write_i = wr; bus.core_amo_i = amo;
        bus.core_addr_i = addr; bus.core_wdata_i = wd;
    endtask

    task automatic clr_req();
        bus.core_req_i = 0; bus.core_write_i = 0; bus.core_amo_i = '0;
    endtask

    task automatic set_rsp(input logic [1:0] id, input logic [31:0] d);
        bus.in_valid_i = 1; bus.in_meta_i = {Ini, Tile, Core, id}; bus.in_rdata_i = d;
    endtask

    task automatic clr_rsp();
        bus.in_valid_i = 0;
    endtask

    task automatic do_reset();
        init_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        got.delete();
    endtask

    task automatic chk_got(input string name, input int i, input logic [31:0] exp);
        if (i < got.size()) chk(name, got[i], exp);
        else chk(name, 64'hbad0_0000 + 64'(i), exp);
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] id);
        set_req(0, 4'h0, addr, 0);
        #1 chk("load_gnt", bus.core_gnt_o, 1);
        chk("load_id", bus.out_meta_o, {Ini, Tile, Core, id});
        step();
        clr_req();
    endtask

    initial begin
        init_inputs();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        chk_en = 1;
        #1 chk("rst_rvalid", bus.core_rvalid_o, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", bus.core_gnt_o, 0);
        chk("rst_ovalid", bus.out_valid_o, 0);
        chk("rst_rdata", bus.core_rdata_o, 0);
        chk("rst_in_ready", bus.in_ready_o, 1);

        // Single load, response three cycles later
        load(32'h100, 2'd0);
        step(); step();
        set_rsp(2'd0, 32'hDEADBEEF);
        #1 chk("t1_rv_early", bus.core_rvalid_o, 0);
        step(); clr_rsp();
        #1 chk("t1_rv", bus.core_rvalid_o, 1);
        chk("t1_rdata", bus.core_rdata_o, 32'hDEADBEEF);
        step();
        #1 chk("t1_empty", bus.core_rvalid_o, 0);
        chk("t1_cnt", got.size(), 1);
        chk_got("t1_got", 0, 32'hDEADBEEF);

        // Out-of-order responses returned in order
        do_reset();
        for (int i = 0; i < 4; i++) load(32'h200 + 32'(4 * i), 2'(i));
        set_rsp(2'd3, 32'hA3); step();
        set_rsp(2'd1, 32'hA1); step();
        set_rsp(2'd0, 32'hA0);
        #1 chk("t2_rv_early", bus.core_rvalid_o, 0);
        step();
        set_rsp(2'd2, 32'hA2);
        #1 chk("t2_rv_first", bus.core_rvalid_o, 1);
        chk("t2_rd_first", bus.core_rdata_o, 32'hA0);
        step(); clr_rsp();
        repeat (4) step();
        for (int i = 0; i < 4; i++) chk_got("t2_order", i, 32'hA0 + 32'(i));

        // Full ROB: store still passes, load waits for the pop, ID wraps to 0
        do_reset();
        for (int i = 0; i < 4; i++) load(32'h300 + 32'(4 * i), 2'(i));
        set_req(0, 4'h0, 32'h310, 0);
        #1 chk("t3_full_gnt", bus.core_gnt_o, 0);
        chk("t3_full_ov", bus.out_valid_o, 0);
        step();
        set_req(1, 4'h0, 32'h314, 32'h55);
        #1 chk("t3_store_gnt", bus.core_gnt_o, 1);
        step();
        set_req(0, 4'h0, 32'h310, 0);
        set_rsp(2'd0, 32'hB0);
        #1 chk("t3_stall_a", bus.core_gnt_o, 0);
        step(); clr_rsp();
        #1 chk("t3_stall_pop", bus.core_gnt_o, 0);
        chk("t3_rv", bus.core_rvalid_o, 1);
        step();
        #1 chk("t3_wrap_gnt", bus.core_gnt_o, 1);
        chk("t3_wrap_id", bus.out_meta_o, {Ini, Tile, Core, 2'd0});
        step(); clr_req();
        set_rsp(2'd1, 32'hB1); step();
        set_rsp(2'd2, 32'hB2); step();
        set_rsp(2'd3, 32'hB3); step();
        set_rsp(2'd0, 32'hB4); step();
        clr_rsp();
        repeat (3) step();
        for (int i = 0; i < 5; i++) chk_got("t3_order", i, 32'hB0 + 32'(i));

        // LR gating: second LR waits, SC passes, LR resumes after first LR's response
        do_reset();
        set_req(0, 4'hA, 32'h400, 0);
        #1 chk("t4_lr1_gnt", bus.core_gnt_o, 1);
        step();
        set_req(0, 4'hA, 32'h404, 0);
        #1 chk("t4_lr2_stall", bus.core_gnt_o, 0);
        step();
        set_req(1, 4'hB, 32'h400, 32'h77);
        #1 chk("t4_sc_gnt", bus.core_gnt_o, 1);
        chk("t4_sc_write", bus.out_write_o, 0);
        chk("t4_sc_id", bus.out_meta_o, {Ini, Tile, Core, 2'd1});
        step();
        set_req(0, 4'hA, 32'h404, 0);
        #1 chk("t4_lr2_stall_b", bus.core_gnt_o, 0);
        step();
        set_rsp(2'd0, 32'hC0);
        #1 chk("t4_lr2_stall_c", bus.core_gnt_o, 0);
        step(); clr_rsp();
        #1 chk("t4_lr2_gnt", bus.core_gnt_o, 1);
        chk("t4_lr2_id", bus.out_meta_o, {Ini, Tile, Core, 2'd2});
        step(); clr_req();
        set_rsp(2'd1, 32'hC1); step();
        set_rsp(2'd2, 32'hC2); step();
        clr_rsp();
        repeat (3) step();
        for (int i = 0; i < 3; i++) chk_got("t4_order", i, 32'hC0 + 32'(i));

        // Core backpressure for 10 cycles
        do_reset();
        bus.core_rready_i = 0;
        for (int i = 0; i < 3; i++) load(32'h500 + 32'(4 * i), 2'(i));
        set_rsp(2'd2, 32'hD2); step();
        set_rsp(2'd0, 32'hD0); step();
        set_rsp(2'd1, 32'hD1); step();
        clr_rsp();
        repeat (7) step();
        #1 chk("t5_hold_rv", bus.core_rvalid_o, 1);
        chk("t5_hold_rd", bus.core_rdata_o, 32'hD0);
        chk("t5_none", got.size(), 0);
        bus.core_rready_i = 1;
        repeat (4) step();
        for (int i = 0; i < 3; i++) chk_got("t5_order", i, 32'hD0 + 32'(i));

        // Spurious response, then reset with requests in flight
        do_reset();
        #1 chk("t6_rdata_clr", bus.core_rdata_o, 0);
        load(32'h600, 2'd0);
        load(32'h604, 2'd1);
        set_rsp(2'd2, 32'hE2); step(); clr_rsp();
        #1 chk("t6_err", err, 1);
        chk("t6_no_rv", bus.core_rvalid_o, 0);
        repeat (3) step();
        #1 chk("t6_err_sticky", err, 1);
        chk("t6_no_rv_b", bus.core_rvalid_o, 0);
        do_reset();
        #1 chk("t6_rst_err", err, 0);
        chk("t6_rst_rv", bus.core_rvalid_o, 0);
        chk("t6_rst_ov", bus.out_valid_o, 0);
        set_rsp(2'd0, 32'hE0); step(); clr_rsp();
        #1 chk("t6_stale_err", err, 1);
        chk("t6_stale_rv", bus.core_rvalid_o, 0);

        // Identity mismatch is dropped; a correct response still lands
        do_reset();
        load(32'h700, 2'd0);
        bus.in_valid_i = 1; bus.in_meta_i = {Ini, 4'h6, Core, 2'd0}; bus.in_rdata_i = 32'hF0;
        step(); clr_rsp();
        #1 chk("t7_id_err", err, 1);
        chk("t7_id_rv", bus.core_rvalid_o, 0);
        set_rsp(2'd0, 32'hF1); step(); clr_rsp();
        #1 chk("t7_ok_rv", bus.core_rvalid_o, 1);
        chk("t7_ok_rd", bus.core_rdata_o, 32'hF1);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
